// File: rtl/shift_sequencer.sv
// Command-driven sequencer for a 4-bit universal shift register: loads a word, issues
// single-bit shift cycles (logical or rotate), then returns the register contents.
module shift_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] sr_out,
    output logic [WIDTH-1:0] sr_par_in,
    output logic             sr_s1,
    output logic             sr_s0,
    output logic             sr_enable,
    output logic             sr_ls,
    output logic             sr_rs,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data
);

    typedef enum logic [2:0] {StIdle, StLoad, StShift, StWait, StResp} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q;
    logic [1:0]         op_q;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]   res_data_q;
    logic               res_valid_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cmd_valid) state_d = StLoad;
            StLoad:  state_d = (count_q == '0) ? StWait : StShift;
            StShift: if (count_q <= CNT_W'(1)) state_d = StWait;
            StWait:  state_d = StResp;
            StResp:  if (res_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Shift amount is loaded into the counter on acceptance; it is consumed from SHIFT on.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            data_q      <= '0;
            op_q        <= '0;
            count_q     <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && cmd_valid) begin
                data_q  <= cmd_data;
                op_q    <= cmd_op;
                count_q <= cmd_amt;
            end
            if (state_q == StShift) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (state_q == StWait) begin
                res_data_q  <= sr_out;
                res_valid_q <= 1'b1;
            end
            if (state_q == StResp && res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        cmd_ready = 1'b0;
        sr_par_in = data_q;
        sr_enable = 1'b0;
        sr_s1     = 1'b0;
        sr_s0     = 1'b1;
        sr_ls     = 1'b0;
        sr_rs     = 1'b0;
        unique case (state_q)
            StIdle: cmd_ready = 1'b1;
            StLoad: begin
                sr_enable = 1'b1;
                sr_s0     = 1'b0;
            end
            StShift: begin
                sr_enable = 1'b1;
                sr_s1     = 1'b1;
                sr_s0     = op_q[0];
                // Rotations recirculate the edge bit that is about to fall off.
                if (op_q[1]) begin
                    if (op_q[0]) sr_rs = sr_out[WIDTH-1];
                    else         sr_ls = sr_out[0];
                end
            end
            default: ;
        endcase
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: drives it against a behavioural 4-bit universal
// shift register and checks results, latency, enable count and command spacing.
module tb_shift_sequencer;

    localparam int W  = 4;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [W-1:0]  cmd_data = '0;
    logic [1:0]    cmd_op = '0;
    logic [CW-1:0] cmd_amt = '0;
    logic [W-1:0]  sr_out;
    logic [W-1:0]  sr_par_in;
    logic          sr_s1, sr_s0, sr_enable, sr_ls, sr_rs;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [W-1:0]  res_data;

    shift_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .sr_out    (sr_out),
        .sr_par_in (sr_par_in),
        .sr_s1     (sr_s1),
        .sr_s0     (sr_s0),
        .sr_enable (sr_enable),
        .sr_ls     (sr_ls),
        .sr_rs     (sr_rs),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
    );

    always #5 clock = ~clock;

    // Driven universal shift register; it has no reset of its own.
    logic [W-1:0] sr_q = '0;
    assign sr_out = sr_q;
    always @(posedge clock) begin
        if (sr_enable) begin
            case ({sr_s1, sr_s0})
                2'b00:   sr_q <= sr_par_in;
                2'b10:   sr_q <= {sr_ls, sr_q[W-1:1]};
                2'b11:   sr_q <= {sr_q[W-2:0], sr_rs};
                default: ;
            endcase
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;
    int t_acc  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [W-1:0] ref_model(input logic [W-1:0] d, input logic [1:0] op,
                                               input logic [CW-1:0] amt);
        int unsigned v = d;
        int unsigned n = amt;
        int unsigned k = n % W;
        int unsigned r;
        case (op)
            2'd0:    r = (n >= W) ? 0 : (v >> n);
            2'd1:    r = (n >= W) ? 0 : (v << n);
            2'd2:    r = (v >> k) | (v << (W - k));
            default: r = (v << k) | (v >> (W - k));
        endcase
        return W'(r & ((1 << W) - 1));
    endfunction

    // Called #1 after an edge; returns #1 after the accepting edge.
    task automatic issue(input logic [W-1:0] d, input logic [1:0] op, input logic [CW-1:0] amt);
        int w = 0;
        cmd_data  = d;
        cmd_op    = op;
        cmd_amt   = amt;
        cmd_valid = 1'b1;
        while (!cmd_ready && w < 50) begin
            @(posedge clock);
            #1;
            w++;
        end
        if (w >= 50) check("accept_timeout", 0, 1);
        @(posedge clock);
        t_acc = cyc;
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_result(input logic [1:0] op, output logic [W-1:0] res, output int lat,
                               output int en, output int sel_ok);
        logic [1:0] exp_sel;
        lat = 0;
        en = 0;
        sel_ok = 1;
        while (!res_valid && lat < 40) begin
            if (sr_enable) begin
                en++;
                exp_sel = (lat == 0) ? 2'b00 : {1'b1, op[0]};
                if ({sr_s1, sr_s0} != exp_sel) sel_ok = 0;
            end
            @(posedge clock);
            #1;
            lat++;
        end
        if (!res_valid) check("result_timeout", 0, 1);
        res = res_data;
    endtask

    typedef struct {
        logic [W-1:0]  data;
        logic [1:0]    op;
        logic [CW-1:0] amt;
        logic [W-1:0]  exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [W-1:0]  res;
        logic [W-1:0]  held;
        logic [W-1:0]  d;
        logic [1:0]    op;
        logic [CW-1:0] amt;
        int lat, en, sel_ok, prev_t, prev_amt, seen;

        vecs[0] = '{4'b0110, 2'd0, 4'd0,  4'b0110};
        vecs[1] = '{4'b1011, 2'd2, 4'd1,  4'b1101};
        vecs[2] = '{4'b1011, 2'd2, 4'd5,  4'b1101};
        vecs[3] = '{4'b1011, 2'd3, 4'd2,  4'b1110};
        vecs[4] = '{4'b0110, 2'd1, 4'd1,  4'b1100};
        vecs[5] = '{4'b0110, 2'd0, 4'd1,  4'b0011};
        vecs[6] = '{4'b0110, 2'd1, 4'd4,  4'b0000};
        vecs[7] = '{4'b0110, 2'd0, 4'd15, 4'b0000};

        repeat (2) @(posedge clock);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_enable", sr_enable, 0);
        check("rst_select", {sr_s1, sr_s0}, 2'b01);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].data, vecs[i].op, vecs[i].amt);
            wait_result(vecs[i].op, res, lat, en, sel_ok);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].amt + 2);
            check($sformatf("vec%0d_enable_cycles", i), en, vecs[i].amt + 1);
            check($sformatf("vec%0d_select", i), sel_ok, 1);
            res_ready = 1'b1;
            @(posedge clock);
            #1;
            res_ready = 1'b0;
            check($sformatf("vec%0d_valid_drop", i), res_valid, 0);
            check($sformatf("vec%0d_idle", i), cmd_ready, 1);
        end

        // Consumer stalls for 10 cycles while stray commands are offered.
        issue(4'b1001, 2'd2, 4'd3);
        wait_result(2'd2, res, lat, en, sel_ok);
        held = ref_model(4'b1001, 2'd2, 4'd3);
        check("stall_result", res, held);
        for (int c = 0; c < 10; c++) begin
            cmd_valid = c[0];
            cmd_data  = W'($urandom);
            @(posedge clock);
            #1;
            check("stall_valid", res_valid, 1);
            check("stall_data", res_data, held);
            check("stall_cmd_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clock);
        #1;
        res_ready = 1'b0;
        check("stall_release_idle", cmd_ready, 1);
        issue(4'b0110, 2'd1, 4'd2);
        wait_result(2'd1, res, lat, en, sel_ok);
        check("post_stall_result", res, 4'b1000);
        res_ready = 1'b1;
        @(posedge clock);
        #1;
        res_ready = 1'b0;

        // Asynchronous reset in the middle of a 4-step shift.
        issue(4'b1011, 2'd2, 4'd4);
        repeat (2) @(posedge clock);
        #1;
        check("mid_enable_before_reset", sr_enable, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_cmd_ready", cmd_ready, 1);
        check("arst_res_valid", res_valid, 0);
        check("arst_res_data", res_data, 0);
        check("arst_par_in", sr_par_in, 0);
        check("arst_enable", sr_enable, 0);
        check("arst_select", {sr_s1, sr_s0}, 2'b01);
        check("arst_fill", {sr_ls, sr_rs}, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock);
            #1;
            if (res_valid || !cmd_ready) seen = 1;
        end
        check("arst_no_result", seen, 0);

        // Back-to-back randomized commands with the consumer always ready.
        res_ready = 1'b1;
        prev_t = 0;
        prev_amt = 0;
        for (int n = 0; n < 30; n++) begin
            d   = W'($urandom);
            op  = 2'($urandom);
            amt = CW'($urandom_range(0, 15));
            issue(d, op, amt);
            if (n > 0) check("b2b_spacing", t_acc - prev_t, prev_amt + 4);
            prev_t = t_acc;
            prev_amt = amt;
            wait_result(op, res, lat, en, sel_ok);
            check("b2b_result", res, ref_model(d, op, amt));
            check("b2b_latency", lat, amt + 2);
            check("b2b_enable_cycles", en, amt + 1);
            check("b2b_select", sel_ok, 1);
            @(posedge clock);
            #1;
            check("b2b_resp_one_cycle", res_valid, 0);
        end
        res_ready = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

endmodule
